// File: rtl/fp8_dot_ctrl.sv
// Sequencer for a two-lane FP8 multiply-accumulate unit: clears the MAC, injects
// the per-lane bias, streams operand beats, waits out the MAC latency and holds the result.
module fp8_dot_ctrl #(
  parameter int DRAIN_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] bias0,
  input  logic [7:0] bias1,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a0,
  input  logic [7:0] in_a1,
  input  logic [7:0] in_b0,
  input  logic [7:0] in_b1,
  output logic       mac_clr,
  output logic [7:0] mac_a0,
  output logic [7:0] mac_a1,
  output logic [7:0] mac_b0,
  output logic [7:0] mac_b1,
  output logic [7:0] mac_c0,
  output logic [7:0] mac_c1,
  input  logic [7:0] mac_facc0,
  input  logic [7:0] mac_facc1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_res0,
  output logic [7:0] out_res1,
  output logic       busy
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    BIAS  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          aborting;
  logic          aborting_nx;
  logic [7:0]    rem;
  logic [7:0]    bias0_q;
  logic [7:0]    bias1_q;
  logic [DW-1:0] dcnt;
  logic          clr_q;
  logic          run_q;
  logic          beat;
  logic          capture;
  logic          load_job;
  logic          load_bias;
  logic          drain_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      aborting <= 1'b0;
    end else begin
      state    <= state_nx;
      aborting <= aborting_nx;
    end
  end

  // Next-state and per-cycle control decode; abort overrides everything outside IDLE
  always_comb begin
    state_nx    = state;
    aborting_nx = aborting;
    beat        = 1'b0;
    capture     = 1'b0;
    load_job    = 1'b0;
    load_bias   = 1'b0;
    drain_last  = (dcnt == DLAST);
    if (abort && (state != IDLE)) begin
      state_nx    = CLEAR;
      aborting_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx    = CLEAR;
            aborting_nx = 1'b0;
            load_job    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        CLEAR: begin
          if (aborting) begin
            state_nx = IDLE;
          end else begin
            state_nx = BIAS;
          end
        end
        BIAS: begin
          load_bias = 1'b1;
          if (rem != 8'd0) begin
            state_nx = RUN;
          end else begin
            state_nx = DRAIN;
          end
        end
        RUN: begin
          if (in_valid) begin
            beat = 1'b1;
            if (rem == 8'd1) begin
              state_nx = DRAIN;
            end else begin
              state_nx = RUN;
            end
          end else begin
            state_nx = RUN;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            capture  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = DRAIN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = IDLE;
          end else begin
            state_nx = DONE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Job parameters, beat counter and drain counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= 8'd0;
      bias0_q <= 8'd0;
      bias1_q <= 8'd0;
      dcnt    <= '0;
    end else begin
      if (load_job) begin
        rem     <= len;
        bias0_q <= bias0;
        bias1_q <= bias1;
      end else if (beat) begin
        rem <= rem - 8'd1;
      end
      if ((state == DRAIN) && (state_nx == DRAIN)) begin
        dcnt <= dcnt + DW'(1);
      end else begin
        dcnt <= '0;
      end
    end
  end

  // MAC operand registers: anything not loaded this cycle goes to zero so the
  // accumulator sees a harmless 0*0+0 on idle and bubble cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_a0 <= 8'h00;
      mac_a1 <= 8'h00;
      mac_b0 <= 8'h00;
      mac_b1 <= 8'h00;
      mac_c0 <= 8'h00;
      mac_c1 <= 8'h00;
    end else begin
      mac_a0 <= beat ? in_a0 : 8'h00;
      mac_a1 <= beat ? in_a1 : 8'h00;
      mac_b0 <= beat ? in_b0 : 8'h00;
      mac_b1 <= beat ? in_b1 : 8'h00;
      mac_c0 <= load_bias ? bias0_q : 8'h00;
      mac_c1 <= load_bias ? bias1_q : 8'h00;
    end
  end

  // Registered status flags and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q     <= 1'b0;
      run_q     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_res0  <= 8'h00;
      out_res1  <= 8'h00;
    end else begin
      clr_q     <= (state_nx == CLEAR);
      run_q     <= (state_nx == RUN);
      busy      <= (state_nx != IDLE);
      out_valid <= (state_nx == DONE);
      if (capture) begin
        out_res0 <= mac_facc0;
        out_res1 <= mac_facc1;
      end
    end
  end

  // Abort masks in_ready so a beat offered in the abort cycle never handshakes
  assign in_ready = run_q & ~abort;
  assign mac_clr  = rst | clr_q;

endmodule

// File: tb/tb_fp8_dot_ctrl.sv
// Self-checking bench for fp8_dot_ctrl with a stand-in MAC (modulo-256 integer
// multiply-accumulate, three-stage output pipeline) and a result scoreboard.
module tb_fp8_dot_ctrl;
  localparam int DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] bias0 = 8'd0;
  logic [7:0] bias1 = 8'd0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a0 = 8'd0, in_a1 = 8'd0, in_b0 = 8'd0, in_b1 = 8'd0;
  logic       mac_clr;
  logic [7:0] mac_a0, mac_a1, mac_b0, mac_b1, mac_c0, mac_c1;
  logic [7:0] mac_facc0 = 8'd0, mac_facc1 = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_res0, out_res1;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] sb[$];
  logic [15:0] last_exp = 16'h0000;
  logic [7:0]  qa0[$], qa1[$], qb0[$], qb1[$];

  fp8_dot_ctrl #(.DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias0(bias0), .bias1(bias1),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .mac_clr(mac_clr), .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_b0(mac_b0), .mac_b1(mac_b1),
    .mac_c0(mac_c0), .mac_c1(mac_c1), .mac_facc0(mac_facc0), .mac_facc1(mac_facc1),
    .out_valid(out_valid), .out_ready(out_ready), .out_res0(out_res0), .out_res1(out_res1),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in MAC: result is final three edges after the operands appear
  logic [7:0] acc0 = 8'd0, acc1 = 8'd0, pa0 = 8'd0, pa1 = 8'd0;
  always @(posedge clk) begin
    if (mac_clr) begin
      acc0 <= 8'd0; acc1 <= 8'd0; pa0 <= 8'd0; pa1 <= 8'd0;
      mac_facc0 <= 8'd0; mac_facc1 <= 8'd0;
    end else begin
      acc0 <= acc0 + mac_a0 * mac_b0 + mac_c0;
      acc1 <= acc1 + mac_a1 * mac_b1 + mac_c1;
      pa0 <= acc0; pa1 <= acc1;
      mac_facc0 <= pa0; mac_facc1 <= pa1;
    end
  end

  // Mid-cycle monitor: handshakes, clear pulses, bias cycles, valid cycles, operand zeroing
  logic        hs_prev = 1'b0;
  logic [31:0] exp_ops = 32'h0;
  int hs_cnt = 0, clr_cnt = 0, c_cnt = 0, ov_cnt = 0, op_bad = 0;
  always @(negedge clk) begin
    if (hs_prev) begin
      if ({mac_a0, mac_a1, mac_b0, mac_b1} !== exp_ops) op_bad <= op_bad + 1;
    end else if ({mac_a0, mac_a1, mac_b0, mac_b1} !== 32'h0) begin
      op_bad <= op_bad + 1;
    end
    hs_prev <= in_valid & in_ready & ~rst;
    exp_ops <= {in_a0, in_a1, in_b0, in_b1};
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (mac_clr && !rst) clr_cnt <= clr_cnt + 1;
    if (mac_c0 !== 8'h00 || mac_c1 !== 8'h00) c_cnt <= c_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    qa0 = {}; qa1 = {}; qb0 = {}; qb1 = {};
    for (int i = 0; i < n; i++) begin
      qa0.push_back(8'($urandom_range(0, 127) * 2 + 1));
      qa1.push_back(8'($urandom_range(0, 127) * 2 + 1));
      qb0.push_back(8'($urandom_range(0, 127) * 2 + 1));
      qb1.push_back(8'($urandom_range(0, 127) * 2 + 1));
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] s0, s1;
    s0 = b0;
    s1 = b1;
    foreach (qa0[i]) begin
      s0 = s0 + 8'(qa0[i] * qb0[i]);
      s1 = s1 + 8'(qa1[i] * qb1[i]);
    end
    return {s1, s0};
  endfunction

  task automatic start_job(input logic [7:0] n, input logic [7:0] b0, input logic [7:0] b1,
                           output int c0);
    start = 1'b1; len = n; bias0 = b0; bias1 = b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic feed(input int nbeats, input int gap1, input int gap2, output logic to);
    logic hs;
    int g;
    to = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1'b1;
      in_a0 = qa0[i]; in_a1 = qa1[i]; in_b0 = qb0[i]; in_b1 = qb1[i];
      hs = 1'b0;
      g = 0;
      while (!hs && g < 300) begin
        @(negedge clk);
        hs = in_ready;
        tick();
        g++;
      end
      in_valid = 1'b0;
      if (!hs) to = 1'b1;
      if (i == 0) repeat (gap1) tick();
      else if (i == 1) repeat (gap2) tick();
    end
  endtask

  task automatic collect(output logic [15:0] res, output int vcyc, output logic to);
    int g;
    g = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    to = (out_valid !== 1'b1);
    res = {out_res1, out_res0};
    vcyc = cyc;
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (mac_clr !== 1'b1) begin
      n_fail++; $display("FAIL reset_mac_clr: got %b expected 1", mac_clr);
    end
    n_checks++;
    if ({busy, in_ready, out_valid, out_res0, out_res1, mac_a0, mac_a1, mac_b0, mac_b1,
         mac_c0, mac_c1} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rdy=%b ov=%b res=%h%h a=%h%h b=%h%h c=%h%h expected all 0",
               busy, in_ready, out_valid, out_res1, out_res0, mac_a1, mac_a0, mac_b1, mac_b0,
               mac_c1, mac_c0);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({mac_clr, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: clr,busy=%b expected 00", {mac_clr, busy});
    end
  endtask

  task automatic test_back_to_back();
    int c0, vc, h0;
    logic to1, to2;
    logic [15:0] r, e;
    fill(4);
    h0 = hs_cnt;
    start_job(8'd4, 8'h00, 8'h00, c0);
    sb.push_back(model(8'h00, 8'h00));
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy);
    end
    feed(4, 0, 0, to1);
    collect(r, vc, to2);
    n_checks++;
    if ({to1, to2} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_timeout: feed/collect=%b expected 00", {to1, to2});
    end
    n_checks++;
    if (hs_cnt - h0 !== 4) begin
      n_fail++; $display("FAIL b2b_handshakes: got %0d expected 4", hs_cnt - h0);
    end
    n_checks++;
    if (vc - c0 !== 2 + 4 + DRAIN) begin
      n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", vc - c0, 2 + 4 + DRAIN);
    end
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if (r !== e) begin
      n_fail++; $display("FAIL b2b_result: got %h expected %h", r, e);
    end
    tick();
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_release: ov,busy=%b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_bubbles();
    int c0, vc, ob0;
    logic to1, to2, to3, to4;
    logic [15:0] r_b2b, r_bub, e;
    fill(3);
    ob0 = op_bad;
    start_job(8'd3, 8'h11, 8'h22, c0);
    sb.push_back(model(8'h11, 8'h22));
    feed(3, 0, 0, to1);
    collect(r_b2b, vc, to2);
    tick();
    start_job(8'd3, 8'h11, 8'h22, c0);
    sb.push_back(model(8'h11, 8'h22));
    feed(3, 2, 5, to3);
    collect(r_bub, vc, to4);
    tick();
    n_checks++;
    if ({to1, to2, to3, to4} !== 4'b0000) begin
      n_fail++; $display("FAIL bub_timeout: flags=%b expected 0000", {to1, to2, to3, to4});
    end
    e = sb.pop_front();
    n_checks++;
    if (r_b2b !== e) begin
      n_fail++; $display("FAIL bub_ref_result: got %h expected %h", r_b2b, e);
    end
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if (r_bub !== e) begin
      n_fail++; $display("FAIL bub_result: got %h expected %h", r_bub, e);
    end
    n_checks++;
    if (vc - c0 !== 2 + 3 + 2 + 5 + DRAIN) begin
      n_fail++; $display("FAIL bub_latency: got %0d expected %0d", vc - c0, 2 + 3 + 7 + DRAIN);
    end
    n_checks++;
    if (op_bad - ob0 !== 0) begin
      n_fail++; $display("FAIL bub_operands: %0d bad operand cycles expected 0", op_bad - ob0);
    end
  endtask

  task automatic test_len0();
    int c0, vc, h0, cc0;
    logic to;
    logic [15:0] r, e;
    fill(0);
    h0 = hs_cnt;
    cc0 = c_cnt;
    start_job(8'd0, 8'h38, 8'h00, c0);
    sb.push_back(model(8'h38, 8'h00));
    collect(r, vc, to);
    tick();
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if (to !== 1'b0 || r !== e) begin
      n_fail++; $display("FAIL len0_result: got %h (timeout %b) expected %h", r, to, e);
    end
    n_checks++;
    if (hs_cnt - h0 !== 0) begin
      n_fail++; $display("FAIL len0_handshakes: got %0d expected 0", hs_cnt - h0);
    end
    n_checks++;
    if (c_cnt - cc0 !== 1) begin
      n_fail++; $display("FAIL len0_bias_cycles: got %0d expected 1", c_cnt - cc0);
    end
    n_checks++;
    if (vc - c0 !== 2 + DRAIN) begin
      n_fail++; $display("FAIL len0_latency: got %0d expected %0d", vc - c0, 2 + DRAIN);
    end
  endtask

  task automatic test_hold();
    int c0, vc, bad;
    logic to1, to2;
    logic [15:0] r, e;
    fill(2);
    out_ready = 1'b0;
    start_job(8'd2, 8'h05, 8'h07, c0);
    sb.push_back(model(8'h05, 8'h07));
    feed(2, 0, 0, to1);
    collect(r, vc, to2);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      start = (k % 3 == 0);
      len = 8'd5;
      @(negedge clk);
      if (out_valid !== 1'b1 || {out_res1, out_res0} !== r) bad++;
    end
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if ({to1, to2} !== 2'b00 || r !== e) begin
      n_fail++; $display("FAIL hold_result: got %h (timeouts %b) expected %h", r, {to1, to2}, e);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL hold_stable: %0d unstable cycles expected 0", bad);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: out_valid=%b expected 0", out_valid);
    end
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_start_ignored: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int c0, vc, clr0, h0, ov0, ob0;
    logic to1, to2, to3;
    logic [15:0] r, e;
    fill(6);
    start_job(8'd6, 8'h01, 8'h02, c0);
    feed(2, 0, 0, to1);
    clr0 = clr_cnt; h0 = hs_cnt; ov0 = ov_cnt; ob0 = op_bad;
    abort = 1'b1;
    in_valid = 1'b1;
    in_a0 = 8'h33; in_a1 = 8'h35; in_b0 = 8'h37; in_b1 = 8'h39;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({mac_clr, busy} !== 2'b11) begin
      n_fail++; $display("FAIL abort_clear: clr,busy=%b expected 11", {mac_clr, busy});
    end
    tick();
    n_checks++;
    if ({mac_clr, busy} !== 2'b00) begin
      n_fail++; $display("FAIL abort_idle: clr,busy=%b expected 00", {mac_clr, busy});
    end
    repeat (6) tick();
    n_checks++;
    if (clr_cnt - clr0 !== 1 || hs_cnt - h0 !== 0 || ov_cnt - ov0 !== 0 || op_bad - ob0 !== 0) begin
      n_fail++;
      $display("FAIL abort_effects: clr=%0d hs=%0d ov=%0d opbad=%0d expected 1 0 0 0",
               clr_cnt - clr0, hs_cnt - h0, ov_cnt - ov0, op_bad - ob0);
    end
    n_checks++;
    if ({out_res1, out_res0} !== last_exp) begin
      n_fail++; $display("FAIL abort_res_hold: got %h expected %h", {out_res1, out_res0}, last_exp);
    end
    fill(1);
    start_job(8'd1, 8'h10, 8'h20, c0);
    sb.push_back(model(8'h10, 8'h20));
    feed(1, 0, 0, to2);
    collect(r, vc, to3);
    tick();
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if ({to1, to2, to3} !== 3'b000 || r !== e) begin
      n_fail++; $display("FAIL abort_next_job: got %h (timeouts %b) expected %h", r, {to1, to2, to3}, e);
    end
  endtask

  task automatic test_reset_mid();
    int c0, vc, ov0;
    logic to1, to2, to3;
    logic [15:0] r, e;
    fill(2);
    start_job(8'd2, 8'h03, 8'h04, c0);
    feed(2, 0, 0, to1);
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, in_ready, out_valid, out_res0, out_res1, mac_a0, mac_a1, mac_b0, mac_b1,
         mac_c0, mac_c1} !== 67'h0 || mac_clr !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_outputs: busy=%b ov=%b res=%h%h clr=%b expected 0 0 0000 1",
                         busy, out_valid, out_res1, out_res0, mac_clr);
    end
    tick();
    n_checks++;
    if (mac_clr !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_clr_held: got %b expected 1", mac_clr);
    end
    rst = 1'b0;
    ov0 = ov_cnt;
    repeat (8) tick();
    n_checks++;
    if (ov_cnt - ov0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_discard: ov=%0d busy=%b expected 0 0", ov_cnt - ov0, busy);
    end
    fill(3);
    start_job(8'd3, 8'h09, 8'h0a, c0);
    sb.push_back(model(8'h09, 8'h0a));
    feed(3, 0, 0, to2);
    collect(r, vc, to3);
    tick();
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if ({to1, to2, to3} !== 3'b000 || r !== e) begin
      n_fail++; $display("FAIL rstmid_next_job: got %h (timeouts %b) expected %h", r, {to1, to2, to3}, e);
    end
  endtask

  task automatic test_len255();
    int c0, vc, h0;
    logic to1, to2;
    logic [15:0] r, e;
    fill(255);
    h0 = hs_cnt;
    start_job(8'd255, 8'h7f, 8'h81, c0);
    sb.push_back(model(8'h7f, 8'h81));
    feed(255, 0, 0, to1);
    collect(r, vc, to2);
    tick();
    e = sb.pop_front();
    last_exp = e;
    n_checks++;
    if (hs_cnt - h0 !== 255) begin
      n_fail++; $display("FAIL len255_handshakes: got %0d expected 255", hs_cnt - h0);
    end
    n_checks++;
    if ({to1, to2} !== 2'b00 || r !== e || vc - c0 !== 2 + 255 + DRAIN) begin
      n_fail++; $display("FAIL len255_result: got %h lat %0d (timeouts %b) expected %h lat %0d",
                         r, vc - c0, {to1, to2}, e, 2 + 255 + DRAIN);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_len0();
    test_hold();
    test_abort();
    test_reset_mid();
    test_len255();
    n_checks++;
    if (sb.size() !== 0 || op_bad !== 0) begin
      n_fail++; $display("FAIL final_state: scoreboard=%0d opbad=%0d expected 0 0", sb.size(), op_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp8_dot_ctrl.md
FP8_DOT_CTRL -- requirements
Module: fp8_dot_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 4: cycles from the last operand beat driven to the MAC until its facc outputs are final.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; one clock; asynchronous, active-high.
- start  in  1  begin a dot-product job; sampled in IDLE only.
- len  in  8  number of element-pair beats in the job; sampled with start.
- bias0, bias1  in  8  FP8 bias, one per lane; sampled with start.
- abort  in  1  synchronous job cancel.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted.
- in_a0, in_a1, in_b0, in_b1  in  8 each  FP8 operands, lanes 0 and 1.
- mac_clr  out  1  accumulator clear to the MAC reset pin.
- mac_a0, mac_a1, mac_b0, mac_b1  out  8 each  operands to the MAC.
- mac_c0, mac_c1  out  8 each  addend to the MAC.
- mac_facc0, mac_facc1  in  8 each  MAC results.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_res0, out_res1  out  8 each  captured lane results.
- busy  out  1  high in any state except IDLE.

Function
REQ-003 SHALL use FSM states IDLE, CLEAR, BIAS, RUN, DRAIN, DONE.
REQ-004 IDLE: on start=1, SHALL latch len into 8-bit beat counter `rem` and latch bias0 and bias1, then go to CLEAR.
REQ-005 CLEAR: SHALL assert mac_clr for exactly one cycle, then go to BIAS.
REQ-006 BIAS (one cycle): SHALL register bias0 and bias1 onto mac_c0 and mac_c1 for exactly one following cycle.
REQ-007 BIAS exit: SHALL go to RUN if rem!=0, else to DRAIN.
REQ-008 RUN: in_ready=1; a beat is in_valid&in_ready.
REQ-009 On each beat, SHALL register in_a*/in_b* onto mac_a*/mac_b* for the next cycle and decrement rem.
REQ-010 SHALL go to DRAIN on the beat that makes rem reach 0.
REQ-011 In RUN, in_valid=0 cycles (bubbles) SHALL be tolerated with no limit.
REQ-012 mac_a*, mac_b*, mac_c* SHALL all be registered, and SHALL be 0x00 in every cycle not loaded per REQ-006/REQ-009, so idle cycles add zero to the accumulator.
REQ-013 DRAIN: SHALL count exactly DRAIN_CYC cycles.
REQ-014 On the last DRAIN cycle, SHALL capture mac_facc0/1 into out_res0/1 and go to DONE.
REQ-015 DONE: out_valid=1.
REQ-016 out_res0/1 SHALL stay stable until out_valid&out_ready.
REQ-017 On out_valid&out_ready, SHALL go to IDLE; out_valid deasserts the next cycle.
REQ-018 in_ready SHALL be 0 outside RUN.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 abort=1 in any non-IDLE state SHALL go to CLEAR-then-IDLE:
- mac_clr pulses for 1 cycle;
- out_valid drops;
- out_res0/1 hold their previous values;
- any beat presented in the abort cycle is not accepted.
REQ-021 abort in IDLE SHALL have no effect.
REQ-022 abort SHALL take priority over start, beats and out_ready in the same cycle.
REQ-023 len=255 SHALL accept exactly 255 beats.
REQ-024 len=0 SHALL accept no beats; the result equals bias0/bias1 after the MAC round-trip.
REQ-025 SHALL perform no FP arithmetic; the MAC datapath owns all rounding and special cases.

Reset
REQ-026 While rst=1, mac_clr SHALL be 1 (mac_clr = rst OR clear pulse).
REQ-027 While rst=1, state SHALL be IDLE.
REQ-028 While rst=1, SHALL drive 0 on: rem; the DRAIN counter; all mac_a*/mac_b*/mac_c*; out_res0/1; out_valid; in_ready; busy.
REQ-029 rst asserted mid-job SHALL discard the job with no result emitted.

Verification
REQ-030 len=4, bias=0x00, four back-to-back beats -> busy 1 cycle after start; exactly 4 in_ready handshakes; out_valid at start+1+1+4+DRAIN_CYC cycles; out_res matches the golden MAC model.
REQ-031 len=3, bubbles after beat 1 (2 cycles) and beat 2 (5 cycles) -> results identical to the back-to-back run; mac_a*/mac_b*=0x00 in every bubble cycle.
REQ-032 len=0, bias0=0x38, bias1=0x00 -> no in_ready; mac_c0=0x38 for exactly 1 cycle; out_res equals the MAC output for 0x38 and 0x00.
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_valid and out_res stable throughout; start pulses during this time are ignored.
REQ-034 abort in RUN after 2 of 6 beats, asserted together with in_valid -> that beat is not accepted; 1-cycle mac_clr; IDLE 2 cycles later; no out_valid; the next job (len=1) completes correctly.
REQ-035 rst pulsed mid-DRAIN -> all outputs 0 immediately; mac_clr=1 during reset; a new start after reset yields a correct result.
